// File: rtl/sha3_digest_axis_tx_if.sv
// AXI-Stream bus bundle for the SHA-3 digest transmitter.
// The master drives data/valid/last/user/keep; the slave returns ready.
interface sha3_digest_axis_tx_if #(
    parameter int DATA_WIDTH = 16
);
    logic                      M_TVALID;
    logic                      M_TREADY;
    logic [DATA_WIDTH-1:0]     M_TDATA;
    logic                      M_TLAST;
    logic [3:0]                M_TUSER;
    logic [DATA_WIDTH/8-1:0]   M_TKEEP;

    modport master (
        output M_TVALID,
        output M_TDATA,
        output M_TLAST,
        output M_TUSER,
        output M_TKEEP,
        input  M_TREADY
    );

    modport slave (
        input  M_TVALID,
        input  M_TDATA,
        input  M_TLAST,
        input  M_TUSER,
        input  M_TKEEP,
        output M_TREADY
    );
endinterface

// File: rtl/sha3_digest_axis_tx.sv
// SHA-3 result transmitter: captures a 1600-bit Keccak state in one handshake
// and streams it out over AXI-Stream, most-significant word first.
// Digest mode sends only the SHA-224/256/384/512 digest words; raw mode sends
// the whole state. TLAST marks the final beat, TUSER[3] the first one.
// Optional build macro SHA3_TX_BYTESWAP_EN: byte-reverse every outgoing word
// for little-endian host buffers (beat order and TLAST unaffected).
module sha3_digest_axis_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int STATE_W    = 1600
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic [STATE_W-1:0]   state_i,
    input  logic                 state_valid_i,
    output logic                 state_ready_o,
    input  logic                 mode_i,
    input  logic [1:0]           user_i,
    sha3_digest_axis_tx_if.master m_axis,
    output logic                 busy_o
);

    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int CNT_W  = 8;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]          fsm_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [STATE_W-1:0]  shift_p0;
    logic                vld_p0;
    logic                last_p0;
    logic [3:0]          user_p0;
    logic [CNT_W-1:0]    n_beats;

    // Number of beats in a packet for the given mode and SHA variant.
    function automatic logic [CNT_W-1:0] beat_count(input logic mode, input logic [1:0] user);
        int unsigned bits;
        case (user)
            2'd0:    bits = 224;
            2'd1:    bits = 256;
            2'd2:    bits = 384;
            default: bits = 512;
        endcase
        if (!mode) begin
            bits = STATE_W;
        end
        beat_count = CNT_W'(bits / DATA_WIDTH);
    endfunction

    // Output word ordering; byte reversal is a no-op for single-byte words.
    function automatic logic [DATA_WIDTH-1:0] byte_order(input logic [DATA_WIDTH-1:0] w);
        logic [DATA_WIDTH-1:0] r;
`ifdef SHA3_TX_BYTESWAP_EN
        for (int b = 0; b < KEEP_W; b++) begin
            r[8*b +: 8] = w[DATA_WIDTH-8-8*b +: 8];
        end
`else
        r = w;
`endif
        return r;
    endfunction

    assign n_beats = beat_count(mode_i, user_i);

    // Capture, serialise and hand off beats; reset discards any packet in flight.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            fsm_q    <= IDLE;
            cnt_q    <= '0;
            shift_p0 <= '0;
            vld_p0   <= 1'b0;
            last_p0  <= 1'b0;
            user_p0  <= 4'd0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (state_valid_i) begin
                        shift_p0 <= state_i;
                        cnt_q    <= n_beats - CNT_W'(1);
                        user_p0  <= {1'b1, mode_i, user_i};
                        vld_p0   <= 1'b1;
                        last_p0  <= (n_beats == CNT_W'(1));
                        fsm_q    <= SEND;
                    end
                end
                SEND: begin
                    if (vld_p0 && m_axis.M_TREADY) begin
                        if (last_p0) begin
                            vld_p0  <= 1'b0;
                            last_p0 <= 1'b0;
                            user_p0 <= 4'd0;
                            fsm_q   <= IDLE;
                        end else if (cnt_q != '0) begin
                            shift_p0   <= shift_p0 << DATA_WIDTH;
                            cnt_q      <= cnt_q - CNT_W'(1);
                            user_p0[3] <= 1'b0;
                            last_p0    <= (cnt_q == CNT_W'(1));
                        end
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign state_ready_o   = (fsm_q == IDLE);
    assign busy_o          = (fsm_q == SEND);
    assign m_axis.M_TVALID = vld_p0;
    assign m_axis.M_TLAST  = last_p0;
    assign m_axis.M_TUSER  = user_p0;
    assign m_axis.M_TDATA  = byte_order(shift_p0[STATE_W-1 -: DATA_WIDTH]);
    assign m_axis.M_TKEEP  = {KEEP_W{vld_p0}};

endmodule

// File: tb/tb_sha3_digest_axis_tx.sv
// Directed bench for sha3_digest_axis_tx at DATA_WIDTH = 16.
// A beat-queue model built from the packet rules is compared against the
// stream on every cycle TVALID is high; a few literals pin the model itself.
module tb_sha3_digest_axis_tx;

    localparam int DW = 16;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic [3:0]  user;
    } beat_t;

    logic          ACLK;
    logic          ARESET;
    logic [1599:0] state_i;
    logic          state_valid_i;
    logic          state_ready_o;
    logic          mode_i;
    logic [1:0]    user_i;
    logic          busy_o;

    sha3_digest_axis_tx_if #(.DATA_WIDTH(DW)) axis ();

    sha3_digest_axis_tx #(.DATA_WIDTH(DW), .STATE_W(1600)) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .state_i       (state_i),
        .state_valid_i (state_valid_i),
        .state_ready_o (state_ready_o),
        .mode_i        (mode_i),
        .user_i        (user_i),
        .m_axis        (axis),
        .busy_o        (busy_o)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int    checks = 0;
    int    errors = 0;
    beat_t q[$];
    int    hs_cnt = 0;
    int    pkt_cnt = 0;
    int    pkt_beats = 0;
    int    exp_n = 0;
    bit    last_pending = 0;
    bit    stall_valid = 0;
    beat_t held;
    bit    bp_en = 0;
    int    bp_ph = 0;
    logic [3:0] bp_pat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [15:0] sw16(input logic [15:0] x);
`ifdef SHA3_TX_BYTESWAP_EN
        return {x[7:0], x[15:8]};
`else
        return x;
`endif
    endfunction

    // Word k of the test state is (0x1234 - k) ^ seed, word 0 on top.
    function automatic logic [1599:0] mk_state(input logic [15:0] seed);
        logic [1599:0] s;
        for (int k = 0; k < 100; k++) begin
            s[1599-16*k -: 16] = (16'h1234 - 16'(k)) ^ seed;
        end
        return s;
    endfunction

    task automatic push_pkt(input logic [1599:0] s, input logic m, input logic [1:0] u);
        int    n;
        beat_t b;
        case (u)
            2'd0: n = 224 / DW;
            2'd1: n = 256 / DW;
            2'd2: n = 384 / DW;
            default: n = 512 / DW;
        endcase
        if (!m) n = 1600 / DW;
        exp_n = n;
        for (int k = 0; k < n; k++) begin
            b.data = sw16(s[1599-16*k -: 16]);
            b.last = (k == n - 1);
            b.user = {(k == 0), m, u};
            q.push_back(b);
        end
    endtask

    // Per-cycle stream compare against the model queue.
    always @(negedge ACLK) begin
        if (ARESET) begin
            q.delete();
            pkt_cnt      = 0;
            last_pending = 0;
            stall_valid  = 0;
        end else begin
            if (last_pending) begin
                chk("ready_after_last", {31'd0, state_ready_o}, 32'd1);
                chk("tvalid_after_last", {31'd0, axis.M_TVALID}, 32'd0);
                last_pending = 0;
            end
            if (axis.M_TVALID) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", {31'd0, axis.M_TVALID}, 32'd0);
                end else begin
                    chk("tdata", {16'd0, axis.M_TDATA}, {16'd0, q[0].data});
                    chk("tlast", {31'd0, axis.M_TLAST}, {31'd0, q[0].last});
                    chk("tuser", {28'd0, axis.M_TUSER}, {28'd0, q[0].user});
                    chk("tkeep", {30'd0, axis.M_TKEEP}, 32'd3);
                    if (stall_valid) begin
                        chk("stall_hold", {11'd0, axis.M_TDATA, axis.M_TLAST, axis.M_TUSER},
                            {11'd0, held.data, held.last, held.user});
                    end
                    if (axis.M_TREADY) begin
                        stall_valid = 0;
                        pkt_cnt++;
                        hs_cnt++;
                        if (q[0].last) begin
                            pkt_beats    = pkt_cnt;
                            pkt_cnt      = 0;
                            last_pending = 1;
                        end
                        void'(q.pop_front());
                    end else begin
                        stall_valid = 1;
                        held.data   = axis.M_TDATA;
                        held.last   = axis.M_TLAST;
                        held.user   = axis.M_TUSER;
                    end
                end
            end
        end
    end

    // Ready driver: always ready, or the 1,0,0,1 backpressure pattern.
    initial begin
        bp_pat = 4'b1001;
        axis.M_TREADY = 1'b1;
        forever begin
            @(posedge ACLK);
            #2;
            if (bp_en) begin
                axis.M_TREADY = bp_pat[bp_ph];
                bp_ph = (bp_ph + 1) % 4;
            end else begin
                axis.M_TREADY = 1'b1;
            end
        end
    end

    task automatic capture(input logic [1599:0] s, input logic m, input logic [1:0] u);
        bit got;
        got = 0;
        @(posedge ACLK);
        #2;
        state_i       = s;
        mode_i        = m;
        user_i        = u;
        state_valid_i = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge ACLK);
            if (state_ready_o && !ARESET) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("capture_timeout", 32'd0, 32'd1);
        else push_pkt(s, m, u);
        @(posedge ACLK);
        #2;
        state_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000; i++) begin
            @(negedge ACLK);
            if (q.size() == 0 && !axis.M_TVALID) return;
        end
        chk("wait_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_hs(input int base, input int n);
        for (int i = 0; i < 500; i++) begin
            @(posedge ACLK);
            #2;
            if (hs_cnt - base >= n) return;
        end
        chk("wait_hs_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, {31'd0, axis.M_TVALID}, 32'd0);
        chk({tag, "_tlast"},  {31'd0, axis.M_TLAST}, 32'd0);
        chk({tag, "_tuser"},  {28'd0, axis.M_TUSER}, 32'd0);
        chk({tag, "_tdata"},  {16'd0, axis.M_TDATA}, 32'd0);
        chk({tag, "_tkeep"},  {30'd0, axis.M_TKEEP}, 32'd0);
        chk({tag, "_busy"},   {31'd0, busy_o}, 32'd0);
        chk({tag, "_ready"},  {31'd0, state_ready_o}, 32'd1);
    endtask

    initial begin
        int base;
        ARESET        = 1'b1;
        state_i       = '0;
        state_valid_i = 1'b0;
        mode_i        = 1'b0;
        user_i        = 2'd0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk_reset_outputs("reset");
        @(posedge ACLK);
        #2;
        ARESET = 1'b0;

        // Reset coinciding with a valid state: nothing captured.
        @(posedge ACLK);
        #2;
        ARESET        = 1'b1;
        state_i       = mk_state(16'h0000);
        mode_i        = 1'b1;
        user_i        = 2'd3;
        state_valid_i = 1'b1;
        @(posedge ACLK);
        #2;
        ARESET        = 1'b0;
        state_valid_i = 1'b0;
        @(negedge ACLK);
        chk_reset_outputs("rst_vs_valid");

        // Digest 512, always ready.
        capture(mk_state(16'h0000), 1'b1, 2'd3);
        chk("model_n_512", exp_n, 32'd32);
        @(negedge ACLK);
        chk("first_beat_data", {16'd0, axis.M_TDATA}, {16'd0, sw16(16'h1234)});
        chk("first_beat_user", {28'd0, axis.M_TUSER}, 32'hF);
        chk("busy_in_send", {31'd0, busy_o}, 32'd1);
        wait_done();
        chk("beats_512", pkt_beats, 32'd32);

        // Digest 224.
        capture(mk_state(16'h5A5A), 1'b1, 2'd0);
        chk("model_n_224", exp_n, 32'd14);
        chk("model_224_last", {16'd0, q[q.size()-1].data}, {16'd0, sw16(16'h487D)});
        wait_done();
        chk("beats_224", pkt_beats, 32'd14);

        // Raw mode.
        capture(mk_state(16'h0000), 1'b0, 2'd2);
        chk("model_n_raw", exp_n, 32'd100);
        chk("model_raw_last", {16'd0, q[q.size()-1].data}, {16'd0, sw16(16'h11D1)});
        wait_done();
        chk("beats_raw", pkt_beats, 32'd100);

        // Backpressure.
        bp_en = 1;
        capture(mk_state(16'hF0F0), 1'b1, 2'd3);
        wait_done();
        bp_en = 0;
        chk("beats_bp", pkt_beats, 32'd32);

        // Reset after beat 10, then a full packet.
        base = hs_cnt;
        capture(mk_state(16'h0F0F), 1'b1, 2'd3);
        wait_hs(base, 10);
        ARESET = 1'b1;
        @(posedge ACLK);
        #2;
        ARESET = 1'b0;
        @(negedge ACLK);
        chk_reset_outputs("mid_reset");
        capture(mk_state(16'h0F0F), 1'b1, 2'd3);
        wait_done();
        chk("beats_after_reset", pkt_beats, 32'd32);

        // Valid pulse during SEND is ignored.
        base = hs_cnt;
        capture(mk_state(16'h3C3C), 1'b1, 2'd1);
        wait_hs(base, 5);
        state_i       = mk_state(16'hFFFF);
        mode_i        = 1'b0;
        user_i        = 2'd3;
        state_valid_i = 1'b1;
        @(negedge ACLK);
        chk("ready_low_in_send", {31'd0, state_ready_o}, 32'd0);
        @(posedge ACLK);
        #2;
        state_valid_i = 1'b0;
        wait_done();
        chk("beats_256", pkt_beats, 32'd16);
        repeat (5) @(negedge ACLK);
        chk("idle_ready", {31'd0, state_ready_o}, 32'd1);
        chk("idle_tvalid", {31'd0, axis.M_TVALID}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
